osd_spi_sequencer: RTL and testbench

Master-side controller that drives the OSD overlay's SPI port (SPI_SCK/SPI_SS3/SPI_DI) from inside the core, without the io controller. It accepts OSD commands over a valid/ready request interface: enable, disable, or write one 256-byte line. It fetches line bytes from a client byte source through a 1-cycle-latency read port. It serialises commands in the OSD's framing: command byte, then payload, MSB first, with data sampled on the rising edge of SCK.

---
 rtl/osd_spi_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_osd_spi_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_spi_sequencer.sv
// osd_spi_sequencer: drives the OSD overlay SPI port (SPI_SCK/SPI_SS3/SPI_DI)
// from inside the core. Accepts enable / disable / write-line commands over a
// valid/ready request port and fetches line bytes through a 1-cycle read port.
// Optional build macro: OSD_SEQ_CLEAR_EN (op3 clears all eight lines; when
// undefined, op3 completes immediately with no SPI activity).
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | ready for a request, SS3 high, SCK low
// S_SHIFT_LO | SCK low for CLK_DIV cycles, DI holds the current bit
// S_SHIFT_HI | SCK high for CLK_DIV cycles, OSD samples DI on the rise
// S_TAIL     | SCK low, DI low, CLK_DIV cycles before releasing SS3
// S_GAP      | SS3 high for SS_GAP cycles before the next request

module osd_spi_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    input  logic [2:0] req_line,
    output logic       req_ready,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DI
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_TAIL,
        S_GAP
    } state_t;

    localparam logic [1:0] OP_DISABLE = 2'd0;
    localparam logic [1:0] OP_ENABLE  = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(SS_GAP - 1);
    localparam logic [8:0] LAST_LONG  = 9'd256;

    function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [2:0] line);
        logic [7:0] cmd;
        case (op)
            OP_DISABLE: cmd = 8'h40;
            OP_ENABLE:  cmd = 8'h41;
            default:    cmd = {5'b00100, line};
        endcase
        return cmd;
    endfunction

    state_t     state, state_n;
    logic [7:0] div_cnt, div_n;
    logic [2:0] bit_cnt, bit_n;
    logic [8:0] byte_cnt, byte_n;
    logic [7:0] shreg, shreg_n;
    logic [1:0] op_q, op_n;
    logic [7:0] fetch_buf;
    logic       rd_pend;
    logic       di_n;
    logic       rd_en_n;
    logic [7:0] rd_addr_n;
    logic       done_n;

    // Start of a new transaction byte: load value and the frame position.
    logic       load_byte;
    logic [7:0] load_val;
    logic       last_byte_hit;
    logic [8:0] byte_inc;

`ifdef OSD_SEQ_CLEAR_EN
    logic [2:0] line_q, line_n;
`endif

    // write and clear frames carry 256 payload bytes after the command byte
    assign last_byte_hit = (byte_cnt == (((op_q == OP_WRITE) || (op_q == OP_CLEAR)) ? LAST_LONG : 9'd0));
    assign byte_inc      = byte_cnt + 9'd1;

    // Next-state, counter and output decisions for the sequencer.
    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        bit_n     = bit_cnt;
        byte_n    = byte_cnt;
        shreg_n   = shreg;
        op_n      = op_q;
        di_n      = SPI_DI;
        rd_en_n   = 1'b0;
        rd_addr_n = rd_addr;
        done_n    = 1'b0;
        load_byte = 1'b0;
        load_val  = 8'h00;
`ifdef OSD_SEQ_CLEAR_EN
        line_n    = line_q;
`endif

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    op_n = req_op;
`ifdef OSD_SEQ_CLEAR_EN
                    line_n    = (req_op == OP_CLEAR) ? 3'd0 : req_line;
                    load_byte = 1'b1;
                    load_val  = cmd_byte(req_op, (req_op == OP_CLEAR) ? 3'd0 : req_line);
                    byte_n    = 9'd0;
                    rd_en_n   = (req_op == OP_WRITE);
                    rd_addr_n = 8'd0;
`else
                    if (req_op == OP_CLEAR) begin
                        done_n = 1'b1;
                    end else begin
                        load_byte = 1'b1;
                        load_val  = cmd_byte(req_op, req_line);
                        byte_n    = 9'd0;
                        rd_en_n   = (req_op == OP_WRITE);
                        rd_addr_n = 8'd0;
                    end
`endif
                end
            end

            S_SHIFT_LO: begin
                if (div_cnt == 8'd0) begin
                    state_n = S_SHIFT_HI;
                    div_n   = DIV_LOAD;
                end else begin
                    div_n = div_cnt - 8'd1;
                end
            end

            S_SHIFT_HI: begin
                if (div_cnt != 8'd0) begin
                    div_n = div_cnt - 8'd1;
                end else if (bit_cnt != 3'd0) begin
                    state_n = S_SHIFT_LO;
                    div_n   = DIV_LOAD;
                    bit_n   = bit_cnt - 3'd1;
                    di_n    = shreg[7];
                    shreg_n = {shreg[6:0], 1'b0};
                end else if (last_byte_hit) begin
                    state_n = S_TAIL;
                    div_n   = DIV_LOAD;
                    di_n    = 1'b0;
                end else begin
                    // byte k+1 starts; fetch k+1 unless it is the final payload byte
                    load_byte = 1'b1;
                    load_val  = (op_q == OP_WRITE) ? fetch_buf : 8'h00;
                    byte_n    = byte_inc;
                    rd_en_n   = (op_q == OP_WRITE) && (byte_inc != LAST_LONG);
                    rd_addr_n = byte_inc[7:0];
                end
            end

            S_TAIL: begin
                if (div_cnt == 8'd0) begin
                    state_n = S_GAP;
                    div_n   = GAP_LOAD;
                end else begin
                    div_n = div_cnt - 8'd1;
                end
            end

            S_GAP: begin
                if (div_cnt != 8'd0) begin
                    div_n = div_cnt - 8'd1;
`ifdef OSD_SEQ_CLEAR_EN
                end else if ((op_q == OP_CLEAR) && (line_q != 3'd7)) begin
                    // next line of a clear: new frame without returning to IDLE
                    line_n    = line_q + 3'd1;
                    load_byte = 1'b1;
                    load_val  = cmd_byte(OP_CLEAR, line_q + 3'd1);
                    byte_n    = 9'd0;
`endif
                end else begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (load_byte) begin
            state_n = S_SHIFT_LO;
            div_n   = DIV_LOAD;
            bit_n   = 3'd7;
            di_n    = load_val[7];
            shreg_n = {load_val[6:0], 1'b0};
        end
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            div_cnt   <= 8'd0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 9'd0;
            shreg     <= 8'd0;
            op_q      <= OP_DISABLE;
            SPI_DI    <= 1'b0;
            SPI_SCK   <= 1'b0;
            SPI_SS3   <= 1'b1;
            rd_en     <= 1'b0;
            rd_addr   <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_n;
            div_cnt   <= div_n;
            bit_cnt   <= bit_n;
            byte_cnt  <= byte_n;
            shreg     <= shreg_n;
            op_q      <= op_n;
            SPI_DI    <= di_n;
            SPI_SCK   <= (state_n == S_SHIFT_HI);
            SPI_SS3   <= (state_n == S_IDLE) || (state_n == S_GAP);
            rd_en     <= rd_en_n;
            rd_addr   <= rd_addr_n;
            busy      <= (state_n != S_IDLE);
            done      <= done_n;
            req_ready <= (state_n == S_IDLE);
        end
    end

    // Byte source answers one cycle after rd_en; hold it until the byte starts.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_pend   <= 1'b0;
            fetch_buf <= 8'h00;
        end else begin
            rd_pend <= rd_en;
            if (rd_pend) begin
                fetch_buf <= rd_data;
            end
        end
    end

`ifdef OSD_SEQ_CLEAR_EN
    // Current line of a multi-frame clear.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            line_q <= 3'd0;
        end else begin
            line_q <= line_n;
        end
    end
`endif

endmodule

// File: tb/tb_osd_spi_sequencer.sv
// tb_osd_spi_sequencer: directed bench for osd_spi_sequencer with a byte
// scoreboard. Expected SPI bytes and fetch addresses are queued when a request
// is issued and popped by a monitor that rebuilds bytes on SCK rising edges.
// Times are expressed relative to the accept edge A: the cycle after A is rel 1.

module tb_osd_spi_sequencer;

    localparam int CLK_DIV = 4;
    localparam int SS_GAP  = 8;
    localparam int F_GAP   = 3;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_op    = 2'd0;
    logic [2:0] req_line  = 3'd0;
    logic       req_ready, rd_en, busy, done, SPI_SCK, SPI_SS3, SPI_DI;
    logic [7:0] rd_addr;
    logic [7:0] rd_data = 8'h00;

    logic       f_valid = 1'b0;
    logic [1:0] f_op    = 2'd0;
    logic [2:0] f_line  = 3'd0;
    logic       f_ready, f_rd_en, f_busy, f_done, f_sck, f_ss3, f_di;
    logic [7:0] f_rd_addr;
    logic [7:0] f_rd_data = 8'h00;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    logic [7:0] addr_q[$];

    osd_spi_sequencer #(.CLK_DIV(CLK_DIV), .SS_GAP(SS_GAP)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_line(req_line), .req_ready(req_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done),
        .SPI_SCK(SPI_SCK), .SPI_SS3(SPI_SS3), .SPI_DI(SPI_DI)
    );

    osd_spi_sequencer #(.CLK_DIV(1), .SS_GAP(F_GAP)) dut_f (
        .clk_sys(clk_sys), .reset(reset),
        .req_valid(f_valid), .req_op(f_op), .req_line(f_line), .req_ready(f_ready),
        .rd_en(f_rd_en), .rd_addr(f_rd_addr), .rd_data(f_rd_data),
        .busy(f_busy), .done(f_done),
        .SPI_SCK(f_sck), .SPI_SS3(f_ss3), .SPI_DI(f_di)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // byte source with one cycle of latency
    always @(posedge clk_sys) if (rd_en) rd_data <= rd_addr ^ 8'hA5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // monitor for the main instance
    logic       prev_sck = 1'b0, prev_ss3 = 1'b1;
    logic [7:0] mon_byte = 8'h00;
    int mon_bits = 0, fall_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int last_fall = 0, last_rise = 0, gap_len = 0;

    always @(negedge clk_sys) begin
        if (reset) begin
            mon_bits = 0;
            prev_sck = 1'b0;
            prev_ss3 = 1'b1;
        end else begin
            if (prev_ss3 && !SPI_SS3) begin
                fall_cnt++;
                last_fall = cyc;
                gap_len   = cyc - last_rise;
                mon_bits  = 0;
            end
            if (!prev_ss3 && SPI_SS3) last_rise = cyc;
            if (SPI_SCK && !prev_sck && !SPI_SS3) begin
                mon_byte = {mon_byte[6:0], SPI_DI};
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_bits = 0;
                    if (exp_q.size() == 0) check("spi_extra_byte", 32'(mon_byte), 32'hFFFF);
                    else check("spi_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                end
            end
            if (rd_en) begin
                rd_cnt++;
                if (addr_q.size() == 0) check("rd_extra", 32'(rd_addr), 32'hFFFF);
                else check("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
            end
            if (done) done_cnt++;
            prev_sck = SPI_SCK;
            prev_ss3 = SPI_SS3;
        end
    end

    // monitor for the CLK_DIV=1 instance
    logic       f_prev_sck = 1'b0;
    logic [7:0] f_shift = 8'h00;
    int f_bits = 0, f_last_rise = 0, f_period = 0;

    always @(negedge clk_sys) begin
        if (f_sck && !f_prev_sck && !f_ss3) begin
            f_shift     = {f_shift[6:0], f_di};
            f_bits++;
            f_period    = cyc - f_last_rise;
            f_last_rise = cyc;
        end
        f_prev_sck = f_sck;
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] line, input bit hold, output int acc);
        @(negedge clk_sys);
        req_op = op; req_line = line; req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 40000; i++) begin
            if (req_ready) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk_sys);
        end
        if (acc < 0) check("accept_timeout", 0, 1);
        @(posedge clk_sys);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_sys);
            if (done) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("done_timeout", 0, 1);
    endtask

    task automatic push_write(input logic [2:0] line);
        exp_q.push_back({5'b00100, line});
        for (int k = 0; k < 256; k++) begin
            exp_q.push_back(8'(k) ^ 8'hA5);
            addr_q.push_back(8'(k));
        end
    endtask

    int a, a2, t, rd0, dc0, fc0;

    initial begin
        reset = 1'b1;
        #1;
        check("rst_ss3",   32'(SPI_SS3),   1);
        check("rst_sck",   32'(SPI_SCK),   0);
        check("rst_di",    32'(SPI_DI),    0);
        check("rst_rd_en", 32'(rd_en),     0);
        check("rst_addr",  32'(rd_addr),   0);
        check("rst_busy",  32'(busy),      0);
        check("rst_done",  32'(done),      0);
        check("rst_ready", 32'(req_ready), 1);
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // enable: single command byte 0x41
        exp_q.push_back(8'h41);
        issue(2'd1, 3'd0, 1'b0, a);
        @(negedge clk_sys);
        check("op1_busy", 32'(busy), 1);
        check("op1_ready_low", 32'(req_ready), 0);
        wait_done(200, t);
        check("op1_ss3_fall_rel", 32'(last_fall - a + 1), 1);
        check("op1_ss3_rise_rel", 32'(last_rise - a + 1), 69);
        check("op1_done_rel", 32'(t - a + 1), 77);
        check("op1_ready_at_done", 32'(req_ready), 1);
        check("op1_queue_empty", 32'(exp_q.size()), 0);

        // write line 5 with rd_data = addr ^ 0xA5
        rd0 = rd_cnt;
        push_write(3'd5);
        issue(2'd2, 3'd5, 1'b0, a);
        wait_done(20000, t);
        check("wr_ss3_rise_rel", 32'(last_rise - a + 1), 16453);
        check("wr_done_rel", 32'(t - a + 1), 16461);
        check("wr_rd_count", 32'(rd_cnt - rd0), 256);
        check("wr_bytes_left", 32'(exp_q.size()), 0);
        check("wr_addr_left", 32'(addr_q.size()), 0);

        // back-to-back: valid held, op1 then op0, second accept on the done cycle
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h40);
        issue(2'd1, 3'd0, 1'b1, a);
        req_op = 2'd0;
        a2 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            if (req_ready) begin
                check("b2b_done_on_accept", 32'(done), 1);
                a2 = cyc + 1;
                break;
            end
        end
        @(posedge clk_sys);
        #1 req_valid = 1'b0;
        check("b2b_accept_edge", 32'(a2 - a), 77);
        wait_done(200, t);
        // SS3 stays high through GAP plus the cycle in which the request is taken
        check("b2b_ss3_high_len", 32'(gap_len), SS_GAP + 1);
        check("b2b_done_rel", 32'(t - a2 + 1), 77);
        check("b2b_queue_empty", 32'(exp_q.size()), 0);

        // async reset while payload byte 100 is being shifted
        push_write(3'd2);
        issue(2'd2, 3'd2, 1'b0, a);
        t = -1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_sys);
            if (rd_en && rd_addr == 8'd100) begin
                t = cyc;
                break;
            end
        end
        check("rst_mid_reached", 32'(t > 0), 1);
        repeat (10) @(negedge clk_sys);
        check("rst_mid_ss3_before", 32'(SPI_SS3), 0);
        dc0 = done_cnt;
        @(posedge clk_sys);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_ss3", 32'(SPI_SS3), 1);
        check("rst_mid_sck", 32'(SPI_SCK), 0);
        check("rst_mid_busy", 32'(busy), 0);
        exp_q.delete();
        addr_q.delete();
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_mid_ready", 32'(req_ready), 1);
        repeat (100) @(negedge clk_sys);
        check("rst_mid_no_done", 32'(done_cnt - dc0), 0);
        check("rst_mid_ss3_idle", 32'(SPI_SS3), 1);

        // CLK_DIV=1 instance, op0
        @(negedge clk_sys);
        f_op = 2'd0; f_valid = 1'b1;
        a = cyc + 1;
        @(posedge clk_sys);
        #1 f_valid = 1'b0;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            if (f_done) begin
                t = cyc;
                break;
            end
        end
        check("fast_done_rel", 32'(t - a + 1), 1 + 16 + 1 + F_GAP);
        check("fast_byte", 32'(f_shift), 32'h40);
        check("fast_bits", 32'(f_bits), 8);
        check("fast_sck_period", 32'(f_period), 2);

        // op3 clear
        fc0 = fall_cnt;
        rd0 = rd_cnt;
        dc0 = done_cnt;
`ifdef OSD_SEQ_CLEAR_EN
        for (int l = 0; l < 8; l++) begin
            exp_q.push_back(8'h20 | 8'(l));
            for (int k = 0; k < 256; k++) exp_q.push_back(8'h00);
        end
        issue(2'd3, 3'd0, 1'b0, a);
        wait_done(140000, t);
        check("clr_frames", 32'(fall_cnt - fc0), 8);
        check("clr_no_fetch", 32'(rd_cnt - rd0), 0);
        check("clr_bytes_left", 32'(exp_q.size()), 0);
        repeat (20) @(negedge clk_sys);
        check("clr_one_done", 32'(done_cnt - dc0), 1);
`else
        issue(2'd3, 3'd0, 1'b0, a);
        wait_done(50, t);
        check("clr_done_rel", 32'(t - a + 1), 1);
        check("clr_busy", 32'(busy), 0);
        repeat (20) @(negedge clk_sys);
        check("clr_no_frame", 32'(fall_cnt - fc0), 0);
        check("clr_no_fetch", 32'(rd_cnt - rd0), 0);
        check("clr_one_done", 32'(done_cnt - dc0), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
